seq_mul_acc: RTL and testbench

SEQ_MUL_ACC -- requirements
Module: seq_mul_acc

---
 rtl/seq_mul_acc.sv | 180 ++++++++++++++++++
 tb/tb_seq_mul_acc.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/seq_mul_acc.sv
`default_nettype none
// ============================================================================
// Module   : seq_mul_acc
// Purpose  : Sequential shift-add multiplier with an accumulating register.
//            One multiplier bit is consumed per clock, so an operation takes
//            WIDTH cycles in RUN followed by a one-cycle DONE state. The
//            completed product can optionally be added into a wide
//            accumulator that carries a sticky overflow flag.
// Ports    : clk        - clock, all state changes on the rising edge
//            reset      - synchronous active-high reset
//            start      - operation request, honoured only in IDLE
//            sign_mode  - 1 = two's-complement operands, 0 = unsigned
//            acc_en     - 1 = add the product into the accumulator
//            acc_clr    - synchronous accumulator / overflow clear
//            a, b       - WIDTH-bit operands (multiplicand, multiplier)
//            busy       - high while the multiply is running
//            done       - one-cycle completion pulse
//            product    - last completed 2*WIDTH-bit product
//            acc        - (2*WIDTH+GUARD)-bit accumulator
//            ovf        - sticky accumulator overflow flag
// Revision : 1.0 - initial release
// ============================================================================
module seq_mul_acc #(
    parameter int WIDTH = 8,
    parameter int GUARD = 4
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       start,
    input  logic                       sign_mode,
    input  logic                       acc_en,
    input  logic                       acc_clr,
    input  logic [WIDTH-1:0]           a,
    input  logic [WIDTH-1:0]           b,
    output logic                       busy,
    output logic                       done,
    output logic [2*WIDTH-1:0]         product,
    output logic [2*WIDTH+GUARD-1:0]   acc,
    output logic                       ovf
);

    localparam int c_PROD_W = 2 * WIDTH;
    localparam int c_ACC_W  = 2 * WIDTH + GUARD;
    localparam int c_CNT_W  = $clog2(WIDTH);
    localparam logic [c_CNT_W-1:0] c_LAST = c_CNT_W'(WIDTH - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t                r_state;
    state_t                w_state_next;

    logic [c_PROD_W-1:0]   r_mcand;     // multiplicand, extended and shifted left each step
    logic [WIDTH-1:0]      r_mplier;    // multiplier, shifted right each step
    logic [c_PROD_W-1:0]   r_part;      // running partial product
    logic [c_CNT_W-1:0]    r_cnt;       // index of the multiplier bit being processed
    logic                  r_sign;
    logic                  r_acc_en;

    logic                  w_last;
    logic [c_PROD_W-1:0]   w_addend;
    logic [c_PROD_W-1:0]   w_part_next;
    logic [c_ACC_W-1:0]    w_prod_ext;
    logic [c_ACC_W:0]      w_sum;
    logic                  w_ovf_cond;
    logic                  w_acc_upd;

    // ------------------------------------------------------------------------
    // State machine
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE:  if (start) w_state_next = S_RUN;
            S_RUN:   if (w_last) w_state_next = S_DONE;
            S_DONE:  w_state_next = S_IDLE;
            default: w_state_next = S_IDLE;
        endcase
    end

    // ------------------------------------------------------------------------
    // Multiply datapath
    // ------------------------------------------------------------------------
    assign w_last   = (r_state == S_RUN) && (r_cnt == c_LAST);
    assign w_addend = r_mplier[0] ? r_mcand : '0;

    // In signed mode the multiplier MSB carries weight -2^(WIDTH-1), so its
    // partial product is subtracted rather than added. Together with the
    // sign-extended multiplicand this yields the exact two's-complement
    // product modulo 2^(2*WIDTH).
    assign w_part_next = (r_sign && w_last) ? (r_part - w_addend)
                                            : (r_part + w_addend);

    // ------------------------------------------------------------------------
    // Accumulate datapath
    // ------------------------------------------------------------------------
    assign w_prod_ext = {{GUARD{r_sign & w_part_next[c_PROD_W-1]}}, w_part_next};
    assign w_sum      = {1'b0, acc} + {1'b0, w_prod_ext};
    assign w_acc_upd  = w_last && r_acc_en;

    // Unsigned overflow is the carry out; signed overflow is two same-sign
    // operands producing a result of the opposite sign.
    assign w_ovf_cond = r_sign
        ? ((acc[c_ACC_W-1] == w_prod_ext[c_ACC_W-1]) &&
           (w_sum[c_ACC_W-1] != acc[c_ACC_W-1]))
        : w_sum[c_ACC_W];

    always_ff @(posedge clk) begin
        if (reset) begin
            r_mcand  <= '0;
            r_mplier <= '0;
            r_part   <= '0;
            r_cnt    <= '0;
            r_sign   <= 1'b0;
            r_acc_en <= 1'b0;
            product  <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
        end else begin
            busy <= (w_state_next == S_RUN);
            done <= (w_state_next == S_DONE);
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_mcand  <= {{WIDTH{sign_mode & a[WIDTH-1]}}, a};
                        r_mplier <= b;
                        r_part   <= '0;
                        r_cnt    <= '0;
                        r_sign   <= sign_mode;
                        r_acc_en <= acc_en;
                    end
                end
                S_RUN: begin
                    r_part   <= w_part_next;
                    r_mcand  <= r_mcand << 1;
                    r_mplier <= r_mplier >> 1;
                    r_cnt    <= r_cnt + 1'b1;
                    if (w_last) begin
                        product <= w_part_next;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            acc <= '0;
            ovf <= 1'b0;
        end else if (w_acc_upd) begin
            if (acc_clr) begin
                // A clear coinciding with an update starts the sum afresh.
                acc <= w_prod_ext;
                ovf <= 1'b0;
            end else begin
                acc <= w_sum[c_ACC_W-1:0];
                if (w_ovf_cond) begin
                    ovf <= 1'b1;
                end
            end
        end else if (acc_clr) begin
            acc <= '0;
            ovf <= 1'b0;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_seq_mul_acc.sv
`default_nettype none
// ============================================================================
// Module   : tb_seq_mul_acc
// Purpose  : Self-checking bench for seq_mul_acc (WIDTH=8, GUARD=4).
//            Table of directed multiply vectors plus hand-written sequences
//            for accumulation, overflow, start-during-busy and mid-run reset.
// Revision : 1.0 - initial release
// ============================================================================
module tb_seq_mul_acc;

    logic        clk;
    logic        reset;
    logic        start;
    logic        sign_mode;
    logic        acc_en;
    logic        acc_clr;
    logic [7:0]  a;
    logic [7:0]  b;
    logic        busy;
    logic        done;
    logic [15:0] product;
    logic [19:0] acc;
    logic        ovf;

    int n_cmp;
    int n_bad;

    seq_mul_acc #(
        .WIDTH(8),
        .GUARD(4)
    ) u_dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .sign_mode (sign_mode),
        .acc_en    (acc_en),
        .acc_clr   (acc_clr),
        .a         (a),
        .b         (b),
        .busy      (busy),
        .done      (done),
        .product   (product),
        .acc       (acc),
        .ovf       (ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        s;
        logic [7:0]  va;
        logic [7:0]  vb;
        logic [15:0] p;
    } vec_t;

    vec_t vt[9];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // One full operation; inputs change on the falling edge, outputs are
    // sampled on the falling edge. j counts falling edges after the accept edge.
    task automatic run_op(input logic s, input logic en, input logic [7:0] xa,
                          input logic [7:0] xb, input logic clr_done,
                          output logic [15:0] p);
        int lat;
        int bc;
        lat = -1;
        bc  = 0;
        p   = 16'hxxxx;
        @(negedge clk);
        sign_mode = s;
        acc_en    = en;
        a         = xa;
        b         = xb;
        start     = 1'b1;
        for (int j = 0; j < 20; j++) begin
            @(negedge clk);
            start   = 1'b0;
            acc_clr = clr_done && (j == 7);
            if (busy) bc++;
            if (done) begin
                lat = j;
                p   = product;
                break;
            end
        end
        acc_clr = 1'b0;
        chk("done_latency", lat, 8);
        chk("busy_cycles", bc, 8);
        @(negedge clk);
        chk("done_one_cycle", {31'd0, done}, 0);
        chk("busy_after_done", {31'd0, busy}, 0);
    endtask

    task automatic pulse_clr();
        @(negedge clk);
        acc_clr = 1'b1;
        @(negedge clk);
        acc_clr = 1'b0;
    endtask

    logic [15:0] p;
    int          dcount;
    int          dpos[4];
    logic [15:0] dprod[4];
    int          dseen;

    initial begin
        n_cmp     = 0;
        n_bad     = 0;
        reset     = 1'b1;
        start     = 1'b0;
        sign_mode = 1'b0;
        acc_en    = 1'b0;
        acc_clr   = 1'b0;
        a         = 8'h00;
        b         = 8'h00;

        vt[0] = '{1'b0, 8'hFF, 8'hFF, 16'hFE01};
        vt[1] = '{1'b1, 8'h80, 8'h80, 16'h4000};
        vt[2] = '{1'b1, 8'hFF, 8'h7F, 16'hFF81};
        vt[3] = '{1'b0, 8'h80, 8'hFF, 16'h7F80};
        vt[4] = '{1'b0, 8'h00, 8'h55, 16'h0000};
        vt[5] = '{1'b1, 8'h7F, 8'h7F, 16'h3F01};
        vt[6] = '{1'b1, 8'h80, 8'h7F, 16'hC080};
        vt[7] = '{1'b1, 8'hFF, 8'hFF, 16'h0001};
        vt[8] = '{1'b0, 8'h03, 8'h05, 16'h000F};

        // Reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_busy", {31'd0, busy}, 0);
        chk("rst_done", {31'd0, done}, 0);
        chk("rst_product", {16'd0, product}, 0);
        chk("rst_acc", {12'd0, acc}, 0);
        chk("rst_ovf", {31'd0, ovf}, 0);
        reset = 1'b0;

        // Directed product table, no accumulation
        for (int i = 0; i < 9; i++) begin
            run_op(vt[i].s, 1'b0, vt[i].va, vt[i].vb, 1'b0, p);
            chk($sformatf("product[%0d]", i), {16'd0, p}, {16'd0, vt[i].p});
        end
        chk("acc_untouched", {12'd0, acc}, 0);

        // start held high during operations: accepts only in IDLE
        for (int i = 0; i < 4; i++) begin
            dpos[i]  = -1;
            dprod[i] = 16'h0;
        end
        dcount = 0;
        @(negedge clk);
        sign_mode = 1'b0;
        acc_en    = 1'b0;
        a         = 8'd3;
        b         = 8'd5;
        start     = 1'b1;
        for (int j = 0; j < 36; j++) begin
            @(negedge clk);
            if (done) begin
                if (dcount < 4) begin
                    dpos[dcount]  = j;
                    dprod[dcount] = product;
                end
                dcount++;
            end
            if (j == 9) begin
                a = 8'd7;
                b = 8'd9;
            end else if (j == 19) begin
                a = 8'd11;
                b = 8'd13;
            end else begin
                a = 8'(j) ^ 8'hA5;
                b = ~(8'(j) ^ 8'hA5);
            end
            if (j >= 20) start = 1'b0;
        end
        chk("busy_start_dones", dcount, 3);
        chk("busy_start_pos0", dpos[0], 8);
        chk("busy_start_pos1", dpos[1], 18);
        chk("busy_start_pos2", dpos[2], 28);
        chk("busy_start_prod0", {16'd0, dprod[0]}, 32'h000F);
        chk("busy_start_prod1", {16'd0, dprod[1]}, 32'h003F);
        chk("busy_start_prod2", {16'd0, dprod[2]}, 32'h008F);

        // Reset during the third RUN cycle
        dseen = 0;
        @(negedge clk);
        sign_mode = 1'b0;
        acc_en    = 1'b1;
        a         = 8'hFF;
        b         = 8'hFF;
        start     = 1'b1;
        for (int j = 0; j < 16; j++) begin
            @(negedge clk);
            start = 1'b0;
            if (j == 2) chk("midrun_busy_before", {31'd0, busy}, 1);
            if (j == 3) chk("midrun_busy_after", {31'd0, busy}, 0);
            if (done) dseen++;
            reset = (j == 2);
        end
        reset = 1'b0;
        chk("midrun_no_done", dseen, 0);
        chk("midrun_product", {16'd0, product}, 0);
        chk("midrun_acc", {12'd0, acc}, 0);
        chk("midrun_ovf", {31'd0, ovf}, 0);

        // Signed accumulation: three -2*3
        pulse_clr();
        for (int i = 0; i < 3; i++) run_op(1'b1, 1'b1, 8'hFE, 8'h03, 1'b0, p);
        chk("signed_acc", {12'd0, acc}, 32'hFFFEE);
        chk("signed_acc_ovf", {31'd0, ovf}, 0);

        // Unsigned overflow after 17 x 255*255
        pulse_clr();
        chk("clr_acc", {12'd0, acc}, 0);
        for (int i = 0; i < 16; i++) run_op(1'b0, 1'b1, 8'hFF, 8'hFF, 1'b0, p);
        chk("acc16", {12'd0, acc}, 32'hFE010);
        chk("ovf16", {31'd0, ovf}, 0);
        run_op(1'b0, 1'b1, 8'hFF, 8'hFF, 1'b0, p);
        chk("acc17", {12'd0, acc}, 32'h0DE11);
        chk("ovf17", {31'd0, ovf}, 1);
        run_op(1'b0, 1'b0, 8'h03, 8'h05, 1'b0, p);
        chk("ovf_sticky", {31'd0, ovf}, 1);
        chk("acc_hold_no_en", {12'd0, acc}, 32'h0DE11);

        // Clear coinciding with an accumulate update
        run_op(1'b0, 1'b1, 8'h02, 8'h03, 1'b1, p);
        chk("clr_upd_acc", {12'd0, acc}, 32'h00006);
        chk("clr_upd_ovf", {31'd0, ovf}, 0);
        pulse_clr();
        chk("final_clr_acc", {12'd0, acc}, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
